// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one ALU between the main datapath (port 0)
// and the address/branch helper (port 1), with valid/ready request and response.
module alu_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int OP_W    = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_rd2,
    input  logic [2*WIDTH-1:0]   req_imm,
    input  logic [1:0]           req_src,
    input  logic [2*OP_W-1:0]    req_op,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 rsp_zero,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_rd2,
    output logic [WIDTH-1:0]     alu_imm,
    output logic                 alu_src,
    output logic [OP_W-1:0]      alu_op,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_zero,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_LAST = 4'(ALU_LAT - 1);

    state_t           state, state_nxt;
    logic             grant, last_grant, pick;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] a_q, rd2_q, imm_q;
    logic             src_q;
    logic [OP_W-1:0]  op_q;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        pick      = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[pick] = 1'b1;
                    state_nxt       = EXEC;
                end
            end
            EXEC: begin
                if (cnt == CNT_LAST) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid[grant] = 1'b1;
                if (rsp_ready[grant]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 4'd0;
            a_q        <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            src_q      <= 1'b0;
            op_q       <= '0;
            rsp_data   <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant <= pick;
                        cnt   <= 4'd0;
                        a_q   <= pick ? req_a[2*WIDTH-1:WIDTH]   : req_a[WIDTH-1:0];
                        rd2_q <= pick ? req_rd2[2*WIDTH-1:WIDTH] : req_rd2[WIDTH-1:0];
                        imm_q <= pick ? req_imm[2*WIDTH-1:WIDTH] : req_imm[WIDTH-1:0];
                        src_q <= pick ? req_src[1]               : req_src[0];
                        op_q  <= pick ? req_op[2*OP_W-1:OP_W]    : req_op[OP_W-1:0];
                    end
                end
                EXEC: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        rsp_data <= alu_result;
                        rsp_zero <= alu_zero;
                    end
                end
                RESP: begin
                    if (rsp_ready[grant]) last_grant <= grant;
                end
                default: ;
            endcase
        end
    end

    // Operand registers feed the ALU directly, so the ALU inputs never glitch.
    assign alu_a   = a_q;
    assign alu_rd2 = rd2_q;
    assign alu_imm = imm_q;
    assign alu_src = src_q;
    assign alu_op  = op_q;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: one arbiter with a behavioural ALU (ALU_LAT=1) and one with
// a bench-driven ALU result (ALU_LAT=3) for capture-timing checks.
module tb_alu_share_arbiter;

    localparam int W  = 32;
    localparam int OW = 4;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]      req_valid = '0, req_src = '0, rsp_ready = '0;
    logic [2*W-1:0]  req_a = '0, req_rd2 = '0, req_imm = '0;
    logic [2*OW-1:0] req_op = '0;
    logic [1:0]      req_ready, rsp_valid;
    logic [W-1:0]    rsp_data, alu_a, alu_rd2, alu_imm, alu_result, alu_b;
    logic            rsp_zero, alu_src, alu_zero, busy;
    logic [OW-1:0]   alu_op;

    logic [1:0]      req_valid3 = '0, rsp_ready3 = '0;
    logic [1:0]      req_ready3, rsp_valid3;
    logic [W-1:0]    rsp_data3, alu_a3, alu_rd23, alu_imm3;
    logic [W-1:0]    alu_result3 = '0;
    logic            alu_zero3 = 1'b0;
    logic            rsp_zero3, alu_src3, busy3;
    logic [OW-1:0]   alu_op3;

    int n_checks = 0;
    int n_err    = 0;

    alu_share_arbiter #(.WIDTH(W), .OP_W(OW), .ALU_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_rd2(req_rd2), .req_imm(req_imm),
        .req_src(req_src), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero),
        .alu_a(alu_a), .alu_rd2(alu_rd2), .alu_imm(alu_imm),
        .alu_src(alu_src), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
    );

    alu_share_arbiter #(.WIDTH(W), .OP_W(OW), .ALU_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a), .req_rd2(req_rd2), .req_imm(req_imm),
        .req_src(req_src), .req_op(req_op),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_data(rsp_data3), .rsp_zero(rsp_zero3),
        .alu_a(alu_a3), .alu_rd2(alu_rd23), .alu_imm(alu_imm3),
        .alu_src(alu_src3), .alu_op(alu_op3),
        .alu_result(alu_result3), .alu_zero(alu_zero3), .busy(busy3)
    );

    // Behavioural ALU behind the ALU_mux: B = ALUSrc ? SignExtend : ReadData2.
    always_comb begin
        alu_b = alu_src ? alu_imm : alu_rd2;
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            default: alu_result = alu_a & alu_b;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] rd2,
                           input logic [W-1:0] imm, input logic src, input logic [OW-1:0] op);
        req_a[i*W +: W]    = a;
        req_rd2[i*W +: W]  = rd2;
        req_imm[i*W +: W]  = imm;
        req_src[i]         = src;
        req_op[i*OW +: OW] = op;
    endtask

    // Called in IDLE with requests applied; walks one full operation on dut.
    task automatic do_op(input string tag, input int g, input logic [1:0] valid_after,
                         input logic [W-1:0] exp_a, input logic [W-1:0] exp_data,
                         input logic exp_zero, input int hold);
        logic [1:0] gbit;
        gbit = 2'b01 << g;
        #1;
        check({tag, ".req_ready"}, 64'(req_ready), 64'(gbit));
        check({tag, ".idle_busy"}, 64'(busy), 64'd0);
        @(negedge clk);
        req_valid = valid_after;
        #1;
        check({tag, ".exec_busy"}, 64'(busy), 64'd1);
        check({tag, ".exec_ready"}, 64'(req_ready), 64'd0);
        check({tag, ".exec_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, ".alu_a"}, 64'(alu_a), 64'(exp_a));
        @(negedge clk);
        rsp_ready = ~gbit;
        for (int k = 0; k < hold; k++) begin
            #1;
            check({tag, ".hold_valid"}, 64'(rsp_valid), 64'(gbit));
            check({tag, ".hold_data"}, 64'(rsp_data), 64'(exp_data));
            check({tag, ".hold_ready"}, 64'(req_ready), 64'd0);
            check({tag, ".hold_busy"}, 64'(busy), 64'd1);
            @(negedge clk);
        end
        #1;
        check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(gbit));
        check({tag, ".rsp_data"}, 64'(rsp_data), 64'(exp_data));
        check({tag, ".rsp_zero"}, 64'(rsp_zero), 64'(exp_zero));
        rsp_ready = gbit;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        check({tag, ".done_busy"}, 64'(busy), 64'd0);
        check({tag, ".done_rsp_valid"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #2;
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst.req_ready", 64'(req_ready), 64'd0);
        check("rst.alu_a", 64'(alu_a), 64'd0);
        check("rst.alu_imm", 64'(alu_imm), 64'd0);
        check("rst.alu_src", 64'(alu_src), 64'd0);
        check("rst.rsp_data", 64'(rsp_data), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle.no_req", 64'(req_ready), 64'd0);

        // 1: requester 0, 5 + 7 = 12
        @(negedge clk);
        set_req(0, 32'd5, 32'd7, 32'd99, 1'b0, OP_ADD);
        set_req(1, 32'd50, 32'd60, 32'd70, 1'b1, OP_SUB);
        req_valid = 2'b01;
        do_op("t1", 0, 2'b00, 32'd5, 32'd12, 1'b0, 0);
        check("t1.alu_rd2_held", 64'(alu_rd2), 64'd7);
        check("t1.alu_src_held", 64'(alu_src), 64'd0);

        // 2: requester 1 with immediate, 100 + (-4) = 96
        set_req(0, 32'd9, 32'd9, 32'd9, 1'b0, OP_SUB);
        set_req(1, 32'd100, 32'd55, 32'hFFFF_FFFC, 1'b1, OP_ADD);
        req_valid = 2'b10;
        do_op("t2", 1, 2'b00, 32'd100, 32'd96, 1'b0, 0);
        check("t2.alu_src", 64'(alu_src), 64'd1);
        check("t2.alu_imm", 64'(alu_imm), 64'hFFFF_FFFC);

        // 3: both valid continuously -> grants 0,1,0,1
        set_req(0, 32'd10, 32'd1, 32'd0, 1'b0, OP_ADD);
        set_req(1, 32'd20, 32'd0, 32'd2, 1'b1, OP_SUB);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++)
            do_op("t3", i % 2, 2'b11, (i % 2) ? 32'd20 : 32'd10,
                  (i % 2) ? 32'd18 : 32'd11, 1'b0, 0);
        req_valid = 2'b00;

        // 4: stall in RESP for 5 cycles; zero result; req1 waits meanwhile
        @(negedge clk);
        set_req(0, 32'hF0, 32'h0F, 32'd0, 1'b0, OP_AND);
        req_valid = 2'b01;
        do_op("t4", 0, 2'b10, 32'hF0, 32'd0, 1'b1, 5);
        do_op("t4b", 1, 2'b00, 32'd20, 32'd18, 1'b0, 0);

        // 5: ALU_LAT=3 captures on the 3rd EXEC cycle only
        @(negedge clk);
        req_valid3 = 2'b01;
        #1;
        check("t5.req_ready", 64'(req_ready3), 64'd1);
        @(negedge clk);
        req_valid3 = 2'b00;
        alu_result3 = 32'h1111;
        #1;
        check("t5.busy", 64'(busy3), 64'd1);
        @(negedge clk);
        alu_result3 = 32'h2222;
        #1;
        check("t5.exec2_valid", 64'(rsp_valid3), 64'd0);
        @(negedge clk);
        alu_result3 = 32'h3333;
        #1;
        check("t5.exec3_valid", 64'(rsp_valid3), 64'd0);
        @(negedge clk);
        alu_result3 = 32'h4444;
        alu_zero3   = 1'b1;
        #1;
        check("t5.rsp_valid", 64'(rsp_valid3), 64'd1);
        check("t5.rsp_data", 64'(rsp_data3), 64'h3333);
        @(negedge clk);
        #1;
        check("t5.data_stable", 64'(rsp_data3), 64'h3333);
        check("t5.zero_stable", 64'(rsp_zero3), 64'd0);
        rsp_ready3 = 2'b01;
        @(negedge clk);
        rsp_ready3 = 2'b00;
        #1;
        check("t5.done_busy", 64'(busy3), 64'd0);

        // 6: reset during EXEC, after a grant to 0 left last_grant = 0
        set_req(0, 32'd3, 32'd4, 32'd0, 1'b0, OP_ADD);
        req_valid = 2'b01;
        do_op("t6a", 0, 2'b00, 32'd3, 32'd7, 1'b0, 0);
        set_req(0, 32'd8, 32'd4, 32'd0, 1'b0, OP_ADD);
        req_valid = 2'b01;
        #1;
        check("t6.ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check("t6.exec_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("t6.rst_busy", 64'(busy), 64'd0);
        check("t6.rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t6.rst_alu_a", 64'(alu_a), 64'd0);
        check("t6.rst_rsp_data", 64'(rsp_data), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        req_valid = 2'b11;
        do_op("t6b", 0, 2'b10, 32'd8, 32'd12, 1'b0, 0);
        do_op("t6c", 1, 2'b00, 32'd20, 32'd18, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
